// File: rtl/display_pkg.sv
// display_pkg: shared constants and state type for the display arbiter
package display_pkg;
  localparam int DIGITS = 6;
  localparam int NIB_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {IDLE, OWN} state_t;
endpackage

// File: rtl/display_arbiter_if.sv
// display_arbiter_if: requester bundle, grant/busy and the six HEX digit buses
interface display_arbiter_if #(parameter int N_REQ = 4);
  import display_pkg::*;
  logic [N_REQ-1:0] req;
  logic [24*N_REQ-1:0] data;
  logic [6*N_REQ-1:0] blank;
  logic [N_REQ-1:0] grant;
  logic busy;
  logic [SEG_W-1:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  modport master (output req, data, blank, input grant, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
  modport slave (input req, data, blank, output grant, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
endinterface

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: nibble to active-low gfedcba segment decoder
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg
);
  // one segment pattern per hex value
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin HEX display sharing with minimum dwell; DISPLAY_OWNER_TAG_EN shows owner index on HEX5
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL_CYC = 50000000,
  parameter int CNT_W = 26
) (
  input logic CLOCK_50,
  input logic rst_n,
  display_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYC - 1);
  localparam logic [OW-1:0] LAST = OW'(N_REQ - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [OW-1:0] ptr, own, idle_w, pre_w;
  logic idle_hit, pre_hit;
  logic [23:0] src [N_REQ];
  logic [5:0] msk [N_REQ];
  logic [SEG_W-1:0] seg [DIGITS];
  logic [SEG_W-1:0] nxt [DIGITS];
  logic [SEG_W-1:0] hex [DIGITS];
  function automatic logic [OW-1:0] inc(input logic [OW-1:0] i);
    return i == LAST ? '0 : i + 1'b1;
  endfunction
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign src[i] = bus.data[24*i +: 24];
    assign msk[i] = bus.blank[6*i +: 6];
  end
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [NIB_W-1:0] nib;
`ifdef DISPLAY_OWNER_TAG_EN
    assign nib = d == DIGITS - 1 ? NIB_W'(own) : src[own][4*d +: NIB_W];
    assign nxt[d] = d != DIGITS - 1 && msk[own][d] ? SEG_BLANK : seg[d];
`else
    assign nib = src[own][4*d +: NIB_W];
    assign nxt[d] = msk[own][d] ? SEG_BLANK : seg[d];
`endif
    hex_to_7seg u_dec (.nib(nib), .seg(seg[d]));
  end
  // round-robin search: lowest offset wins, idle search from ptr, preempt search after the owner
  always_comb begin
    idle_hit = 1'b0;
    idle_w = ptr;
    pre_hit = 1'b0;
    pre_w = own;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      logic [OW-1:0] a, b;
      a = OW'((int'(ptr) + k) % N_REQ);
      b = OW'((int'(own) + k) % N_REQ);
      if (bus.req[a]) begin
        idle_hit = 1'b1;
        idle_w = a;
      end
      if (k > 0 && bus.req[b]) begin
        pre_hit = 1'b1;
        pre_w = b;
      end
    end
  end
  // ownership FSM with registered grant, busy and segment outputs; release beats expiry
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      cnt <= '0;
      ptr <= '0;
      own <= '0;
      hex <= '{default: SEG_BLANK};
    end else if (state == IDLE) begin
      hex <= '{default: SEG_BLANK};
      if (idle_hit) begin
        state <= OWN;
        bus.grant <= N_REQ'(1) << idle_w;
        bus.busy <= 1'b1;
        own <= idle_w;
        cnt <= '0;
      end
    end else if (!bus.req[own]) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      ptr <= inc(own);
      hex <= '{default: SEG_BLANK};
    end else begin
      hex <= nxt;
      if (cnt == CNT_MAX && pre_hit) begin
        bus.grant <= N_REQ'(1) << pre_w;
        own <= pre_w;
        cnt <= '0;
        ptr <= inc(pre_w);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.HEX0 = hex[0];
  assign bus.HEX1 = hex[1];
  assign bus.HEX2 = hex[2];
  assign bus.HEX3 = hex[3];
  assign bus.HEX4 = hex[4];
  assign bus.HEX5 = hex[5];
endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the six 7-segment digits (HEX0..HEX5) among N_REQ requesters, e.g. switch echo, complement view and counter.
- Uses round-robin arbitration with a minimum dwell time, so a requester keeps the display for at least DWELL_CYC cycles before it can be preempted.
- Sits between the lab datapaths and the board HEX pins.
- Owns the nibble-to-segment decode for every digit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DWELL_CYC, 50000000, minimum ownership time in clock cycles (1 s at 50 MHz).
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W >= DWELL_CYC.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  N_REQ  requester i asks for the display while req[i]=1.
- data  in  24*N_REQ  requester i owns bits [24i+23:24i]; nibble d (bits 4d+3:4d within the slice) drives HEXd.
- blank  in  6*N_REQ  blank[6i+d]=1 turns HEXd off while requester i owns the display.
- grant  out  N_REQ  one-hot owner indication; all zero when idle.
- busy  out  1  =1 when the arbiter is in state OWN.
- HEX0..HEX5  out  7 each  active-low segments, bit order gfedcba.

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE, grant=0, busy=0.
  - dwell counter=0, round-robin pointer ptr=0.
  - All HEX outputs = 7'b1111111 (blank).
- State IDLE:
  - HEX0..5 are blank.
  - If req is nonzero, pick the first set bit searching ptr, ptr+1, ... with wrap modulo N_REQ.
  - Next edge: grant = onehot(winner), state=OWN, counter=0.
- State OWN, owner o:
  - Each edge, HEXd is registered from decode(data nibble d of o), or 7'b1111111 if blank[6o+d]=1.
  - First valid HEX value appears 1 cycle after grant rises. Data changes are tracked with 1-cycle latency.
  - Counter increments each cycle and saturates at DWELL_CYC-1.
- Release: if req[o]=0 at an edge:
  - grant=0, state=IDLE, ptr=(o+1) mod N_REQ.
  - HEX blank from that edge.
  - The display stays blank for at least one cycle before the next grant.
- Preemption: if counter==DWELL_CYC-1, req[o]=1, and some other req[j]=1:
  - Winner j is chosen round-robin starting at (o+1) mod N_REQ.
  - Grant moves directly to j on the same edge, with no idle gap.
  - counter=0, ptr=(j+1) mod N_REQ.
- No competitor at expiry: owner keeps the grant indefinitely with the counter saturated. A later competing request preempts on the next edge.
- Release and expiry at the same edge: release wins (IDLE path).
- A requester asserting req for a single cycle is granted only if it wins arbitration at that edge. Grant is then withdrawn at the next edge because req has fallen (release).
- grant is always one-hot or zero. Never two bits set.
- Decode for nibbles 0..F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Optional Feature:
- Macro: DISPLAY_OWNER_TAG_EN.
- Defined: while in OWN, HEX5 shows decode(o) regardless of data nibble 5 and blank[6o+5]. HEX5 is blank in IDLE.
- Undefined: HEX5 behaves like HEX0..4.

Decomposition:
- Package display_pkg:
  - SEG_BLANK = 7'b1111111.
  - DIGITS = 6, NIB_W = 4, SEG_W = 7.
  - State typedef {IDLE, OWN}.
- One sub-module, hex_to_7seg: combinational 4-bit to 7-bit decoder, instantiated six times. Owner-tag and blank muxing stay in the parent.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 → grant=0, busy=0, all HEX=1111111. Release reset → grant=0001 after 1 edge; HEX0 reflects req0 data one cycle later.
- Single requester: req=0100 with data2=24'h0003FF → grant=0100; 2 edges later HEX0=0001110 (F), HEX1=0001110 (F), HEX2=0110000 (3), HEX3..5=1000000 (0).
- Dwell/preempt (DWELL_CYC=8): req0 held, req2 asserted at cycle 2 → grant stays 0001 until counter reaches 7, then goes 0100 directly with no idle cycle. ptr=3 afterwards.
- Release round-robin: owner 1 drops req while req=1101 → 1 idle cycle with HEX blank, then grant=0100. Next release → grant=1000, then 0001 (wrap).
- Blank mask: owner 0, blank[5:0]=6'b111000, data=24'hABCDEF → HEX3..5=1111111, HEX0=0001110, HEX1=0000110, HEX2=0100001. With DISPLAY_OWNER_TAG_EN: HEX5=1000000.
- Simultaneous release and expiry (DWELL_CYC=4): at counter=3 owner drops req while req3=1 → state IDLE for 1 cycle, then grant=1000.
